// File: rtl/seq_mult_controller.sv
// seq_mult_controller
//   Sequencing FSM for a shift-and-add sequential multiplier datapath.
//   Once a start is accepted, it clears the product accumulator and loads
//   both operand registers. It then runs WORD_LENGTH add-decision/shift
//   pairs and finally pulses done for one cycle.
//
// Ports
//   clk             rising-edge system clock
//   reset           synchronous, active-high reset
//   start           multiply request, only honoured in IDLE
//   abort           cancel an operation in LOAD/EVAL/SHIFT
//   multiplierLsb   bit 0 of the multiplier register
//   loadRegs        parallel-load both operand registers
//   shiftRegs       shift both operand registers one position
//   multiplicandLoR multiplicand shift direction (always 0, left)
//   multiplierLoR   multiplier shift direction (always 1, right)
//   accClear        zero the product accumulator
//   accEnable       add multiplicand into accumulator this cycle
//   busy            high in every state except IDLE
//   done            one-cycle pulse when the product is valid
module seq_mult_controller #(
  parameter int WORD_LENGTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic multiplierLsb,
  output logic loadRegs,
  output logic shiftRegs,
  output logic multiplicandLoR,
  output logic multiplierLoR,
  output logic accClear,
  output logic accEnable,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(WORD_LENGTH) + 1;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WORD_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] bit_count;
  logic             eval_q;

  // Next-state decode. Abort only matters while an operation is in
  // flight; unused encodings fall back to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? LOAD : IDLE;
      LOAD:    next_state = abort ? IDLE : EVAL;
      EVAL:    next_state = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)
          next_state = IDLE;
        else if (bit_count == LAST_SHIFT)
          next_state = DONE;
        else
          next_state = EVAL;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, shift counter and the Moore outputs are all registered.
  // The outputs are decoded from next_state, so they line up with the
  // state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_count <= '0;
      loadRegs  <= 1'b0;
      shiftRegs <= 1'b0;
      accClear  <= 1'b0;
      eval_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      loadRegs  <= (next_state == LOAD);
      accClear  <= (next_state == LOAD);
      shiftRegs <= (next_state == SHIFT);
      eval_q    <= (next_state == EVAL);
      done      <= (next_state == DONE);
      busy      <= (next_state != IDLE);
      if (state == LOAD)
        bit_count <= '0;
      else if (abort && (state == EVAL || state == SHIFT))
        bit_count <= '0;
      else if (state == SHIFT)
        bit_count <= bit_count + 1'b1;
    end
  end

  // The add decision is the only output that depends on a live input.
  assign accEnable       = eval_q & multiplierLsb;
  assign multiplicandLoR = 1'b0;
  assign multiplierLoR   = 1'b1;

endmodule

// File: tb/tb_seq_mult_controller.sv
// tb_seq_mult_controller
//   Self-checking bench for seq_mult_controller. A small operand-register
//   model feeds multiplierLsb. The expected add-decision bits are queued
//   whenever a start is issued and are popped on each EVAL cycle.
module tb_seq_mult_controller;

  localparam int WL = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic abort;
  logic multiplierLsb;
  logic loadRegs;
  logic shiftRegs;
  logic multiplicandLoR;
  logic multiplierLoR;
  logic accClear;
  logic accEnable;
  logic busy;
  logic done;

  logic [WL-1:0] operand = '0;
  logic [WL-1:0] mreg = '0;
  bit            acc_q[$];
  int            vectors = 0;
  int            miscompares = 0;

  seq_mult_controller #(.WORD_LENGTH(WL)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .multiplierLsb(multiplierLsb),
    .loadRegs(loadRegs),
    .shiftRegs(shiftRegs),
    .multiplicandLoR(multiplicandLoR),
    .multiplierLoR(multiplierLoR),
    .accClear(accClear),
    .accEnable(accEnable),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Multiplier register model: loads on loadRegs and shifts right on shiftRegs.
  always @(posedge clk) begin
    if (loadRegs)
      mreg <= operand;
    else if (shiftRegs)
      mreg <= mreg >> 1;
  end

  assign multiplierLsb = mreg[0];

  // Bit order: {loadRegs, shiftRegs, multiplicandLoR, multiplierLoR,
  //             accClear, accEnable, busy, done}
  wire [7:0] obs = {loadRegs, shiftRegs, multiplicandLoR, multiplierLoR,
                    accClear, accEnable, busy, done};

  localparam logic [7:0] IDLE_VEC = 8'b0001_0000;

  // Expected output vector c cycles after start is sampled.
  function automatic logic [7:0] expected_at(input int c, input bit acc);
    if (c == 1)
      return 8'b1001_1010;
    else if (c >= 2 && c <= 2*WL && (c % 2) == 0)
      return {5'b0001_0, acc, 2'b10};
    else if (c >= 3 && c <= 2*WL + 1)
      return 8'b0101_0010;
    else if (c == 2*WL + 2)
      return 8'b0001_0011;
    else
      return IDLE_VEC;
  endfunction

  function automatic bit is_eval(input int c);
    return (c >= 2 && c <= 2*WL && (c % 2) == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_operand(input logic [WL-1:0] op);
    operand = op;
    for (int i = 0; i < WL; i++)
      acc_q.push_back(op[i]);
  endtask

  task automatic test_reset();
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++;
      if (obs !== IDLE_VEC) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", c, obs, IDLE_VEC);
      end
    end
  endtask

  task automatic test_multiply(input string name, input logic [WL-1:0] op);
    bit a;
    logic [7:0] exp;
    push_operand(op);
    start = 1'b1;
    for (int c = 1; c <= 2*WL + 4; c++) begin
      step();
      start = 1'b0;
      a = 1'b0;
      if (is_eval(c)) begin
        if (acc_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL %s_queue cycle %0d: got empty expected bit", name, c);
        end else begin
          a = acc_q.pop_front();
        end
      end
      exp = expected_at(c, a);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, c, obs, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit a;
    logic [7:0] exp;
    push_operand(8'h3C);
    start = 1'b1;
    for (int c = 1; c <= 2*WL + 6; c++) begin
      step();
      start = (c == 5);
      a = 1'b0;
      if (is_eval(c)) begin
        if (acc_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL busy_start_queue cycle %0d: got empty expected bit", c);
        end else begin
          a = acc_q.pop_front();
        end
      end
      exp = expected_at(c, a);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL busy_start cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_abort();
    bit a;
    int rel;
    logic [7:0] exp;
    push_operand(8'hB6);
    start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      start = (c == 10);
      abort = (c == 7);
      if (c == 8)
        acc_q.delete();
      if (c == 10)
        push_operand(8'h59);
      rel = (c <= 7) ? c : ((c >= 11) ? c - 10 : 0);
      a = 1'b0;
      if (rel != 0 && is_eval(rel)) begin
        if (acc_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL abort_queue cycle %0d: got empty expected bit", c);
        end else begin
          a = acc_q.pop_front();
        end
      end
      exp = expected_at(rel, a);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL abort cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit a;
    int rel;
    logic [7:0] exp;
    push_operand(8'hC3);
    start = 1'b1;
    for (int c = 1; c <= 47; c++) begin
      step();
      start = (c < 40);
      reset = (c == 25);
      if (c == 19)
        push_operand(8'hC3);
      if (c == 26) begin
        acc_q.delete();
        push_operand(8'hC3);
      end
      if (c <= 19)
        rel = c;
      else if (c <= 25)
        rel = c - 19;
      else if (c == 26)
        rel = 0;
      else
        rel = c - 26;
      a = 1'b0;
      if (is_eval(rel)) begin
        if (acc_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL b2b_queue cycle %0d: got empty expected bit", c);
        end else begin
          a = acc_q.pop_front();
        end
      end
      exp = expected_at(rel, a);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", c, obs, exp);
      end
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    test_reset();
    test_multiply("pattern_a5", 8'b1010_0101);
    test_multiply("zero_mult", 8'h00);
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
